// File: rtl/apb_cnt_timer_if.sv
// APB slave-side bus bundle for apb_cnt_timer: the decoded select plus the
// shared apb_xx_* signals from the bridge and the combinational read data.
interface apb_cnt_timer_if;
   logic        psel;
   logic        apb_xx_penable;
   logic        apb_xx_pwrite;
   logic [31:0] apb_xx_paddr;
   logic [31:0] apb_xx_pwdata;
   logic [31:0] prdata;

   modport master (
      output psel,
      output apb_xx_penable,
      output apb_xx_pwrite,
      output apb_xx_paddr,
      output apb_xx_pwdata,
      input  prdata
   );

   modport slave (
      input  psel,
      input  apb_xx_penable,
      input  apb_xx_pwrite,
      input  apb_xx_paddr,
      input  apb_xx_pwdata,
      output prdata
   );
endinterface

// File: rtl/apb_cnt_timer.sv
// 32-bit down-counting APB timer, one-shot or periodic, level interrupt on expiry.
// Optional 8-bit prescaler at offset 0x14 when APB_CNT_TIMER_PRESCALE_EN is defined.
module apb_cnt_timer #(
   parameter int ADDR_LSB_W = 12
) (
   input  logic             hclk,
   input  logic             hrst,
   apb_cnt_timer_if.slave   apb,
   output logic             timer_int
);

   typedef enum logic {
      ST_STOP = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int OFF_W = ADDR_LSB_W - 2;

   localparam logic [OFF_W-1:0] OFF_LOAD     = OFF_W'(0);
   localparam logic [OFF_W-1:0] OFF_VALUE    = OFF_W'(1);
   localparam logic [OFF_W-1:0] OFF_CTRL     = OFF_W'(2);
   localparam logic [OFF_W-1:0] OFF_EOI      = OFF_W'(3);
   localparam logic [OFF_W-1:0] OFF_INTSTAT  = OFF_W'(4);
   localparam logic [OFF_W-1:0] OFF_PRESCALE = OFF_W'(5);

   state_e      state_q,     state_d;
   logic [31:0] load_q,      load_d;
   logic [31:0] value_q,     value_d;
   logic [2:0]  ctrl_q,      ctrl_d;
   logic        intstat_q,   intstat_d;
   logic        timer_int_q, timer_int_d;
`ifdef APB_CNT_TIMER_PRESCALE_EN
   logic [7:0]  presc_q,     presc_d;
   logic [7:0]  pcnt_q,      pcnt_d;
`endif

   logic [OFF_W-1:0] off;
   logic             wr_stb;
   logic             rd_stb;
   logic             ctrl_wr;
   logic             tick;
   logic [31:0]      rdata;
   logic             unused_paddr;

   // The bridge has already decoded the window; only the word offset matters here.
   assign off          = apb.apb_xx_paddr[ADDR_LSB_W-1:2];
   assign unused_paddr = ^{apb.apb_xx_paddr[31:ADDR_LSB_W], apb.apb_xx_paddr[1:0]};

   assign wr_stb  = apb.psel & apb.apb_xx_penable &  apb.apb_xx_pwrite;
   assign rd_stb  = apb.psel & apb.apb_xx_penable & ~apb.apb_xx_pwrite;
   assign ctrl_wr = wr_stb && (off == OFF_CTRL);

`ifdef APB_CNT_TIMER_PRESCALE_EN
   assign tick = (pcnt_q == presc_q);
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      state_d     = state_q;
      load_d      = load_q;
      value_d     = value_q;
      ctrl_d      = ctrl_q;
      intstat_d   = intstat_q;
`ifdef APB_CNT_TIMER_PRESCALE_EN
      presc_d     = presc_q;
      pcnt_d      = pcnt_q;
      if (wr_stb && (off == OFF_PRESCALE)) begin
         presc_d = apb.apb_xx_pwdata[7:0];
      end
`endif

      if (wr_stb && (off == OFF_LOAD)) begin
         load_d = apb.apb_xx_pwdata;
      end

      // EOI clear comes first so a same-edge expiry below overrides it.
      if (rd_stb && (off == OFF_EOI)) begin
         intstat_d = 1'b0;
      end

      case (state_q)
         ST_STOP: begin
            if (ctrl_wr) begin
               ctrl_d = apb.apb_xx_pwdata[2:0];
               if (apb.apb_xx_pwdata[0]) begin
                  state_d = ST_RUN;
                  value_d = load_q;
`ifdef APB_CNT_TIMER_PRESCALE_EN
                  pcnt_d  = 8'd0;
`endif
               end
            end
         end

         ST_RUN: begin
            if (ctrl_wr && !apb.apb_xx_pwdata[0]) begin
               // Disabling wins over a coincident expiry: VALUE freezes as-is.
               ctrl_d  = apb.apb_xx_pwdata[2:0];
               state_d = ST_STOP;
            end else begin
               if (ctrl_wr) begin
                  ctrl_d = apb.apb_xx_pwdata[2:0];
               end
`ifdef APB_CNT_TIMER_PRESCALE_EN
               pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
`endif
               if (tick) begin
                  if (value_q != 32'd0) begin
                     value_d = value_q - 32'd1;
                  end else begin
                     intstat_d = 1'b1;
                     if (ctrl_q[1]) begin
                        value_d = load_q;
                     end else begin
                        ctrl_d[0] = 1'b0;
                        state_d   = ST_STOP;
                     end
                  end
               end
            end
         end

         default: state_d = ST_STOP;
      endcase

      timer_int_d = intstat_q & ctrl_q[2];
   end

   always_comb begin
      rdata = 32'd0;
      if (apb.psel) begin
         case (off)
            OFF_LOAD:     rdata = load_q;
            OFF_VALUE:    rdata = value_q;
            OFF_CTRL:     rdata = {29'd0, ctrl_q};
            OFF_INTSTAT:  rdata = {31'd0, intstat_q};
`ifdef APB_CNT_TIMER_PRESCALE_EN
            OFF_PRESCALE: rdata = {24'd0, presc_q};
`endif
            default:      rdata = 32'd0;
         endcase
      end
   end

   assign apb.prdata = rdata;
   assign timer_int  = timer_int_q;

   always_ff @(posedge hclk or posedge hrst) begin
      if (hrst) begin
         state_q     <= ST_STOP;
         load_q      <= 32'd0;
         value_q     <= 32'd0;
         ctrl_q      <= 3'd0;
         intstat_q   <= 1'b0;
         timer_int_q <= 1'b0;
`ifdef APB_CNT_TIMER_PRESCALE_EN
         presc_q     <= 8'd0;
         pcnt_q      <= 8'd0;
`endif
      end else begin
         state_q     <= state_d;
         load_q      <= load_d;
         value_q     <= value_d;
         ctrl_q      <= ctrl_d;
         intstat_q   <= intstat_d;
         timer_int_q <= timer_int_d;
`ifdef APB_CNT_TIMER_PRESCALE_EN
         presc_q     <= presc_d;
         pcnt_q      <= pcnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_apb_cnt_timer.sv
// Directed bench for apb_cnt_timer: register map, periodic/one-shot counting,
// interrupt/EOI timing, same-edge collisions, prescaler or its absence, async reset.
module tb_apb_cnt_timer;

   localparam logic [31:0] A_LOAD  = 32'h4001_1000;
   localparam logic [31:0] A_VALUE = 32'h4001_1004;
   localparam logic [31:0] A_CTRL  = 32'h4001_1008;
   localparam logic [31:0] A_EOI   = 32'h4001_100C;
   localparam logic [31:0] A_ISTAT = 32'h4001_1010;
   localparam logic [31:0] A_PRESC = 32'h4001_1014;
   localparam logic [31:0] A_UNMAP = 32'h4001_1018;

   logic hclk;
   logic hrst;
   logic timer_int;
   int   errors = 0;
   int   checks = 0;

   apb_cnt_timer_if bus ();

   apb_cnt_timer #(.ADDR_LSB_W(12)) dut (
      .hclk      (hclk),
      .hrst      (hrst),
      .apb       (bus),
      .timer_int (timer_int)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge hclk);
         #1;
      end
   endtask

   // Combinational look at a register inside one cycle; no strobe reaches an edge.
   task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      bus.psel           = 1'b1;
      bus.apb_xx_penable = 1'b1;
      bus.apb_xx_pwrite  = 1'b0;
      bus.apb_xx_paddr   = addr;
      #1;
      chk(tag, bus.prdata, exp);
      bus.psel           = 1'b0;
      bus.apb_xx_penable = 1'b0;
   endtask

   // Full APB write: setup edge, then the write edge; returns 1 ns after the write edge.
   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      bus.psel           = 1'b1;
      bus.apb_xx_penable = 1'b0;
      bus.apb_xx_pwrite  = 1'b1;
      bus.apb_xx_paddr   = addr;
      bus.apb_xx_pwdata  = data;
      @(posedge hclk);
      #1 bus.apb_xx_penable = 1'b1;
      @(posedge hclk);
      #1;
      bus.psel           = 1'b0;
      bus.apb_xx_penable = 1'b0;
      bus.apb_xx_pwrite  = 1'b0;
   endtask

   // Full APB read: data sampled in the access phase; read edge is the second edge.
   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      bus.psel           = 1'b1;
      bus.apb_xx_penable = 1'b0;
      bus.apb_xx_pwrite  = 1'b0;
      bus.apb_xx_paddr   = addr;
      @(posedge hclk);
      #1 bus.apb_xx_penable = 1'b1;
      #1 data = bus.prdata;
      @(posedge hclk);
      #1;
      bus.psel           = 1'b0;
      bus.apb_xx_penable = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] d;
      logic [31:0] exp_val [8];
      logic        exp_ist [8];
      logic        exp_irq [8];

      bus.psel           = 1'b0;
      bus.apb_xx_penable = 1'b0;
      bus.apb_xx_pwrite  = 1'b0;
      bus.apb_xx_paddr   = 32'd0;
      bus.apb_xx_pwdata  = 32'd0;
      hrst               = 1'b1;

      // Reset state
      #3;
      chk("rst_prdata", bus.prdata, 32'd0);
      chk("rst_irq", {31'd0, timer_int}, 32'd0);
      @(posedge hclk);
      #3 hrst = 1'b0;
      step(1);
      peek(A_LOAD,  32'd0, "rst_load");
      peek(A_VALUE, 32'd0, "rst_value");
      peek(A_CTRL,  32'd0, "rst_ctrl");
      peek(A_EOI,   32'd0, "rst_eoi");
      peek(A_ISTAT, 32'd0, "rst_intstat");
      peek(A_PRESC, 32'd0, "rst_presc");
      peek(A_UNMAP, 32'd0, "rst_unmapped");
      wr(A_UNMAP, 32'hDEAD_BEEF);
      peek(A_UNMAP, 32'd0, "unmapped_wr");

      // Periodic: LOAD=3, CTRL=7; enable edge T, expiries at T+4, T+8, T+12
      wr(A_LOAD, 32'd3);
      peek(A_LOAD, 32'd3, "load_rb");
      wr(A_CTRL, 32'h7);
      peek(A_VALUE, 32'd3, "per_value_t0");
      exp_val = '{32'd2, 32'd1, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd3};
      exp_ist = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_irq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 8; i++) begin
         step(1);
         peek(A_VALUE, exp_val[i], $sformatf("per_value_t%0d", i + 1));
         peek(A_ISTAT, {31'd0, exp_ist[i]}, $sformatf("per_intstat_t%0d", i + 1));
         chk($sformatf("per_irq_t%0d", i + 1), {31'd0, timer_int}, {31'd0, exp_irq[i]});
      end
      rd(A_EOI, d);
      chk("per_eoi_data", d, 32'd0);
      peek(A_ISTAT, 32'd0, "per_eoi_clear");
      chk("per_irq_r", {31'd0, timer_int}, 32'd1);
      step(1);
      chk("per_irq_r1", {31'd0, timer_int}, 32'd0);
      peek(A_VALUE, 32'd0, "per_value_t11");
      step(1);
      peek(A_ISTAT, 32'd1, "per_intstat_t12");
      peek(A_VALUE, 32'd3, "per_value_t12");
      chk("per_irq_t12", {31'd0, timer_int}, 32'd0);
      step(1);
      chk("per_irq_t13", {31'd0, timer_int}, 32'd1);
      wr(A_CTRL, 32'h0);
      rd(A_EOI, d);
      step(1);
      chk("per_irq_off", {31'd0, timer_int}, 32'd0);

      // One-shot: LOAD=5, CTRL=5; single expiry at T+6
      wr(A_LOAD, 32'd5);
      wr(A_CTRL, 32'h5);
      exp_val = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
      exp_ist = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         step(1);
         peek(A_VALUE, exp_val[i], $sformatf("os_value_t%0d", i + 1));
         peek(A_ISTAT, {31'd0, exp_ist[i]}, $sformatf("os_intstat_t%0d", i + 1));
      end
      peek(A_CTRL, 32'h4, "os_ctrl_after");
      step(1);
      chk("os_irq", {31'd0, timer_int}, 32'd1);
      rd(A_EOI, d);
      step(8);
      peek(A_ISTAT, 32'd0, "os_no_reexpire");
      peek(A_VALUE, 32'd0, "os_value_hold");
      peek(A_CTRL,  32'h4, "os_ctrl_hold");
      chk("os_irq_off", {31'd0, timer_int}, 32'd0);

      // Collision: EOI read edge == expiry edge T+4, set wins
      wr(A_LOAD, 32'd3);
      wr(A_CTRL, 32'h3);
      step(2);
      peek(A_ISTAT, 32'd0, "col_eoi_pre");
      rd(A_EOI, d);
      peek(A_ISTAT, 32'd1, "col_eoi_intstat");
      peek(A_VALUE, 32'd3, "col_eoi_value");
      // Clear at T+6, then CTRL=0 lands on the T+8 expiry edge: write wins
      rd(A_EOI, d);
      peek(A_ISTAT, 32'd0, "col_dis_pre");
      wr(A_CTRL, 32'h0);
      peek(A_ISTAT, 32'd0, "col_dis_intstat");
      peek(A_VALUE, 32'd0, "col_dis_value");
      peek(A_CTRL,  32'd0, "col_dis_ctrl");
      step(3);
      peek(A_VALUE, 32'd0, "col_dis_frozen");
      peek(A_ISTAT, 32'd0, "col_dis_noset");

`ifdef APB_CNT_TIMER_PRESCALE_EN
      // Prescale 2, LOAD 1, periodic: expiries at T+6, T+12
      wr(A_PRESC, 32'd2);
      peek(A_PRESC, 32'd2, "psc_rb");
      wr(A_LOAD, 32'd1);
      wr(A_CTRL, 32'h3);
      exp_val = '{32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd1};
      exp_ist = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         step(1);
         peek(A_VALUE, exp_val[i], $sformatf("psc_value_t%0d", i + 1));
         peek(A_ISTAT, {31'd0, exp_ist[i]}, $sformatf("psc_intstat_t%0d", i + 1));
      end
      rd(A_EOI, d);
      step(3);
      peek(A_ISTAT, 32'd0, "psc_intstat_t11");
      step(1);
      peek(A_ISTAT, 32'd1, "psc_intstat_t12");
      wr(A_CTRL, 32'h0);
      wr(A_PRESC, 32'd0);
      rd(A_EOI, d);
`else
      wr(A_PRESC, 32'hFF);
      peek(A_PRESC, 32'd0, "no_presc_rb");
`endif

      // LOAD=0 expires every tick; a LOAD write in RUN applies at the next reload
      wr(A_LOAD, 32'd0);
      wr(A_CTRL, 32'h7);
      step(1);
      peek(A_ISTAT, 32'd1, "l0_intstat");
      wr(A_LOAD, 32'h13);
      peek(A_VALUE, 32'd0, "l0_value_old_load");
      step(1);
      peek(A_VALUE, 32'h13, "l0_value_reload");
      step(3);
      peek(A_VALUE, 32'h10, "l0_value_10");
      chk("l0_irq", {31'd0, timer_int}, 32'd1);

      // Asynchronous reset mid-count
      #2 hrst = 1'b1;
      #1;
      chk("ar_irq", {31'd0, timer_int}, 32'd0);
      peek(A_VALUE, 32'd0, "ar_value");
      peek(A_LOAD,  32'd0, "ar_load");
      peek(A_CTRL,  32'd0, "ar_ctrl");
      peek(A_ISTAT, 32'd0, "ar_intstat");
      @(posedge hclk);
      #3 hrst = 1'b0;
      step(4);
      peek(A_VALUE, 32'd0, "ar_post_value");
      peek(A_ISTAT, 32'd0, "ar_post_intstat");
      peek(A_CTRL,  32'd0, "ar_post_ctrl");
      chk("ar_post_irq", {31'd0, timer_int}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
